// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - boot/run/halt arbiter for one shared single-port memory
// Optional stall counters: define MEM_ARB_PERF_CNT_EN.
module mem_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR       = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic             core_hold,
   input  logic             fin,
   input  logic             ld_valid,
   input  logic [ADDR-1:0]  ld_addr,
   input  logic [WIDTH-1:0] ld_wdata,
   input  logic             ld_done,
   input  logic             if_req,
   input  logic [ADDR-1:0]  if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   input  logic             d_req,
   input  logic [ADDR-1:0]  d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   input  logic [3:0]       d_wr_en,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             mem_en,
   output logic [ADDR-1:0]  mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_wr_en,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [31:0]      if_stall_cnt,
   output logic [31:0]      d_stall_cnt
);

   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [1:0] state;
   logic [3:0] starve_cnt;
   logic       own_if;
   logic       own_d;
   logic       in_run;

   assign in_run    = (state == RUN);
   assign core_hold = !in_run;
   assign if_gnt    = in_run && if_req && (!d_req || (starve_cnt >= SMAX));
   assign d_gnt     = in_run && d_req && !if_gnt;

   always_comb begin
      mem_en    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr_en = 4'h0;
      if (state == BOOT && ld_valid) begin
         mem_en    = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
         mem_wr_en = 4'hF;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end else if (d_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wr_en = d_wr_en;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         case (state)
            BOOT:    if (ld_done) state <= RUN;
            RUN:     if (fin) state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !in_run || !if_req || if_gnt) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt < SMAX) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // One-entry owner: the memory answers exactly one cycle after each read grant.
   always_ff @(posedge clk) begin
      own_if <= !reset && if_gnt;
      own_d  <= !reset && d_gnt && (d_wr_en == 4'h0);
   end

   assign if_rvalid = own_if && !reset;
   assign d_rvalid  = own_d && !reset;
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         if_stall_cnt <= 32'd0;
         d_stall_cnt  <= 32'd0;
      end else if (in_run) begin
         if (if_req && !if_gnt) if_stall_cnt <= if_stall_cnt + 32'd1;
         if (d_req && !d_gnt)   d_stall_cnt  <= d_stall_cnt + 32'd1;
      end
   end
`else
   assign if_stall_cnt = 32'd0;
   assign d_stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table plus read-return scoreboard for mem_arbiter
module tb_mem_arbiter;

   typedef struct {
      logic        rst, ldv, ldd, fn, ifr, dr;
      logic [15:0] la;
      logic [31:0] lw;
      logic [15:0] ia, da;
      logic [31:0] dw;
      logic [3:0]  we;
      logic        eh, eifg, edg, eldw, np;
   } vec_t;

   typedef struct {
      int          due;
      logic        port;
      logic [31:0] data;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset, core_hold, fin, ld_valid, ld_done;
   logic [15:0] ld_addr, if_addr, d_addr, mem_addr;
   logic [31:0] ld_wdata, d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic        if_req, if_gnt, if_rvalid, d_req, d_gnt, d_rvalid, mem_en;
   logic [3:0]  d_wr_en, mem_wr_en;
   logic [31:0] if_stall_cnt, d_stall_cnt;

   int          compares = 0;
   int          fails = 0;
   int          cyc = 0;
   sb_t         q[$];
   logic [31:0] mem [64];
   logic [31:0] shadow [64];
   logic [31:0] e_ifs, e_ds;
   vec_t        tbl [13];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.WIDTH(32), .ADDR(16), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset), .core_hold(core_hold), .fin(fin),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_en(d_wr_en), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
      .mem_rdata(mem_rdata), .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
   );

   // Memory macro: registered read, byte-enabled write.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr_en == 4'h0) mem_rdata <= mem[mem_addr[5:0]];
         else for (int b = 0; b < 4; b++)
            if (mem_wr_en[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endfunction

   function automatic vec_t mk(input logic rst, ldv, ldd, fn, ifr, dr,
                               input logic [15:0] la, input logic [31:0] lw,
                               input logic [15:0] ia, da, input logic [31:0] dw,
                               input logic [3:0] we, input logic eh, eifg, edg, eldw, np);
      vec_t v;
      v.rst = rst; v.ldv = ldv; v.ldd = ldd; v.fn = fn; v.ifr = ifr; v.dr = dr;
      v.la = la; v.lw = lw; v.ia = ia; v.da = da; v.dw = dw; v.we = we;
      v.eh = eh; v.eifg = eifg; v.edg = edg; v.eldw = eldw; v.np = np;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      logic        x_en;
      logic [15:0] x_addr;
      logic [31:0] x_wdata;
      logic [3:0]  x_wr;
      sb_t         e;
      @(posedge clk);
      #1;
      reset = v.rst; ld_valid = v.ldv; ld_done = v.ldd; fin = v.fn;
      if_req = v.ifr; d_req = v.dr; ld_addr = v.la; ld_wdata = v.lw;
      if_addr = v.ia; d_addr = v.da; d_wdata = v.dw; d_wr_en = v.we;
      #3;
      x_en = 1'b0; x_addr = 16'h0; x_wdata = 32'h0; x_wr = 4'h0;
      if (v.eldw) begin
         x_en = 1'b1; x_addr = v.la; x_wdata = v.lw; x_wr = 4'hF;
      end else if (v.eifg) begin
         x_en = 1'b1; x_addr = v.ia;
      end else if (v.edg) begin
         x_en = 1'b1; x_addr = v.da; x_wdata = v.dw; x_wr = v.we;
      end
      chk("core_hold", core_hold, v.eh);
      chk("if_gnt", if_gnt, v.eifg);
      chk("d_gnt", d_gnt, v.edg);
      chk("mem_en", mem_en, x_en);
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
      chk("mem_wr_en", mem_wr_en, x_wr);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("if_stall_cnt", if_stall_cnt, e_ifs);
      chk("d_stall_cnt", d_stall_cnt, e_ds);
      if (v.rst) begin
         e_ifs = 32'd0; e_ds = 32'd0;
      end else if (!v.eh) begin
         if (v.ifr && !v.eifg) e_ifs = e_ifs + 32'd1;
         if (v.dr && !v.edg) e_ds = e_ds + 32'd1;
      end
`else
      chk("if_stall_cnt", if_stall_cnt, 32'd0);
      chk("d_stall_cnt", d_stall_cnt, 32'd0);
`endif
      if (!v.np && (v.eifg || (v.edg && v.we == 4'h0))) begin
         e.due = cyc + 1;
         e.port = v.edg;
         e.data = v.eifg ? shadow[v.ia[5:0]] : shadow[v.da[5:0]];
         q.push_back(e);
      end
      if (v.eldw) shadow[v.la[5:0]] = v.lw;
      if (v.edg) for (int b = 0; b < 4; b++)
         if (v.we[b]) shadow[v.da[5:0]][8*b +: 8] = v.dw[8*b +: 8];
   endtask

   // Read-return monitor: every rvalid must match a scoreboard entry due this cycle.
   initial begin
      sb_t  e;
      logic x_i, x_d;
      forever begin
         @(posedge clk);
         #6;
         x_i = 1'b0; x_d = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            x_i = !e.port;
            x_d = e.port;
         end
         chk("if_rvalid", if_rvalid, x_i);
         chk("d_rvalid", d_rvalid, x_d);
         if (x_i) chk("if_rdata", if_rdata, e.data);
         if (x_d) chk("d_rdata", d_rdata, e.data);
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hC0DE0000 + i;
         shadow[i] = 32'hC0DE0000 + i;
      end
      mem_rdata = 32'h0;
      e_ifs = 32'd0; e_ds = 32'd0;
      reset = 1'b1; ld_valid = 1'b0; ld_done = 1'b0; fin = 1'b0;
      if_req = 1'b0; d_req = 1'b0; ld_addr = 16'h0; ld_wdata = 32'h0;
      if_addr = 16'h0; d_addr = 16'h0; d_wdata = 32'h0; d_wr_en = 4'h0;

      //            rst ldv ldd fn ifr dr  la  lw          ia  da  dw            we    eh ifg dg ldw np
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,         4'h0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h13, 0, 0, 32'h0,         4'h0, 1, 0, 0, 1, 0);
      tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1, 32'h93, 0, 0, 32'h0,         4'h0, 1, 0, 0, 1, 0);
      tbl[3]  = mk(0, 1, 0, 0, 0, 0, 2, 32'h73, 0, 0, 32'h0,         4'h0, 1, 0, 0, 1, 0);
      tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0, 32'h0,  0, 0, 32'h0,         4'h0, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,  0, 0, 32'h0,         4'h0, 0, 1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h0,  1, 5, 32'h0,         4'h0, 0, 0, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,  0, 5, 32'hAABBCCDD,  4'h3, 0, 0, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,  0, 5, 32'h0,         4'h0, 0, 0, 1, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,  2, 0, 32'h0,         4'h0, 0, 1, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 1, 0, 0, 0, 0, 9, 32'h77, 0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);

      @(posedge clk);
      for (int i = 0; i < 13; i++) run_vec(tbl[i]);

      // Both ports hammering: data wins four times, then the starved fetch.
      for (int i = 0; i < 10; i++)
         run_vec(mk(0, 0, 0, 0, 1, 1, 0, 32'h0, 1, 4, 32'h0, 4'h0, 0, (i % 5) == 4, (i % 5) != 4, 0, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));

      // Finish: the fin-cycle fetch still goes through, then everything parks.
      run_vec(mk(0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 1, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 5, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(1, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));

      // Reset beats ld_done; then load-with-done in the same cycle.
      run_vec(mk(1, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(0, 1, 1, 0, 0, 0, 3, 32'h55, 0, 0, 32'h0, 4'h0, 1, 0, 0, 1, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));

      // Reset right after a fetch grant discards the pending return.
      run_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 4'h0, 0, 1, 0, 0, 1));
      run_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 1, 1, 0, 32'h0, 3, 4, 32'h0, 4'h0, 0, 0, 1, 0, 0));
      run_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 3, 0, 32'h0, 4'h0, 0, 1, 0, 0, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #8;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the core's instruction-fetch port, the core's data port, and an external program loader. It sequences the boot load, holds the core while the load runs, arbitrates fetch and data accesses at run time with a starvation guard, and parks everything once the core signals `fin`. It sits between the `riscv` core ports and the memory macro.

## Interface
Parameters:
- `WIDTH`, 32: data width.
- `ADDR`, 16: word-address width of the shared memory.
- `STARVE_MAX`, 4: number of consecutive denied fetch cycles after which fetch wins over data. Legal range 1..15.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `core_hold` output 1: keeps the core in reset; high in BOOT and HALT.
- `fin` input 1: core finished (ecall).
- `ld_valid` input 1: loader write strobe.
- `ld_addr` input ADDR: loader address.
- `ld_wdata` input WIDTH: loader data.
- `ld_done` input 1: loader finished; one-cycle pulse.
- `if_req` input 1: fetch request.
- `if_addr` input ADDR: fetch address.
- `if_gnt` output 1: fetch granted this cycle.
- `if_rvalid` output 1: fetch data valid.
- `if_rdata` output WIDTH: fetch data.
- `d_req` input 1: data request.
- `d_addr` input ADDR: data address.
- `d_wdata` input WIDTH: data write data.
- `d_wr_en` input 4: byte write enables; all zero means read.
- `d_gnt` output 1: data granted this cycle.
- `d_rvalid` output 1: data read data valid.
- `d_rdata` output WIDTH: data read data.
- `mem_en` output 1: memory access enable.
- `mem_addr` output ADDR: memory address.
- `mem_wdata` output WIDTH: memory write data.
- `mem_wr_en` output 4: memory byte write enables.
- `mem_rdata` input WIDTH: memory read data; valid the cycle after a read access.
- `if_stall_cnt` output 32: fetch-denied cycle count.
- `d_stall_cnt` output 32: data-denied cycle count.

## Operation
- There are three states: BOOT, RUN and HALT. Reset puts the block in BOOT.
- **BOOT**
  - `core_hold`=1.
  - `if_gnt` and `d_gnt` are 0.
  - A cycle with `ld_valid`=1 drives a full-word write: `mem_en`=1, `mem_wr_en`=4'hF, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_wdata`.
  - `ld_done`=1 moves to RUN on the next cycle. If `ld_valid` is also high in that cycle, the write is still performed.
- **RUN**
  - `core_hold`=0. Loader inputs are ignored.
  - Each cycle at most one requester is granted. Data has priority over fetch.
  - Exception: fetch is granted instead of data when both request and `starve_cnt` ≥ `STARVE_MAX`.
  - The grant is combinational in the same cycle. `mem_*` are muxed from the granted port.
  - A fetch grant is always a read (`mem_wr_en`=0).
  - A data grant passes `d_wr_en` through.
  - `fin`=1 moves to HALT on the next cycle. Requests in the `fin` cycle are still arbitrated normally.
- **HALT**
  - `core_hold`=1.
  - No grants. `mem_en`=0.
  - Only `reset` exits HALT.
- **Starvation counter** (`starve_cnt`):
  - Increments on any RUN cycle with `if_req`=1 and `if_gnt`=0.
  - Clears on a fetch grant, on any cycle with `if_req`=0, and outside RUN.
  - Saturates at `STARVE_MAX`.
- **Read return**
  - A one-entry owner register records which port got a read grant (fetch, or data with `d_wr_en`=0).
  - On the next cycle that port's `rvalid`=1.
  - `if_rdata` and `d_rdata` are both driven from `mem_rdata` and are meaningful only while the matching `rvalid` is high.
  - Data writes produce no `rvalid`.
- **Idle outputs**: `mem_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wr_en`=0.

## Timing
- **Reset values**:
  - state=BOOT, `core_hold`=1.
  - `if_rvalid`=`d_rvalid`=0, owner register empty.
  - `starve_cnt`=0, stall counters=0.
  - Grants and `mem_*` are 0 because they are derived from BOOT with no `ld_valid`.
- **Latency**: grant in cycle N, `rvalid` in cycle N+1. Back-to-back grants give one read return per cycle.
- **Reset mid-operation**: a pending owner is discarded, so there is no `rvalid` in the cycle after `reset`. The state returns to BOOT.
- **Handshake**: a requester holds `req`, `addr` and `wdata` stable until it sees `gnt`. The arbiter keeps no request queue.
- **Simultaneous `ld_done` and reset**: reset wins, and the state stays BOOT.

## Configuration
- `MEM_ARB_PERF_CNT_EN` defined:
  - `if_stall_cnt` increments on each RUN cycle with `if_req`=1 and `if_gnt`=0.
  - `d_stall_cnt` increments likewise for data.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- **Boot load**:
  - Stimulus: reset, then `ld_valid` at addresses 0, 1, 2 with data 0x13, 0x93, 0x73, then `ld_done`.
  - Expected: three writes with `mem_wr_en`=4'hF, and `core_hold` falls exactly one cycle after `ld_done`.
- **Conflict**:
  - Stimulus: in RUN, `if_req` and `d_req` (read, `d_addr`=5) in the same cycle.
  - Expected: `d_gnt`=1, `if_gnt`=0, `mem_addr`=5, and the next cycle `d_rvalid`=1 with `d_rdata`=`mem_rdata`.
- **Starvation**:
  - Stimulus: `STARVE_MAX`=4, `d_req` and `if_req` held high continuously.
  - Expected grant pattern: data×4, fetch×1, repeating.
  - With perf enabled, `if_stall_cnt`=4 after the first 5 cycles.
- **Data write**:
  - Stimulus: `d_req` with `d_wr_en`=4'b0011.
  - Expected: `mem_wr_en`=4'b0011 and no `d_rvalid` the next cycle.
- **Finish**:
  - Stimulus: `fin` pulse while `if_req` is held.
  - Expected: the `fin`-cycle fetch is granted; afterwards `core_hold`=1 and no grants, until reset returns the block to BOOT.
- **Reset mid-read**:
  - Stimulus: fetch granted, then `reset` asserted the next cycle.
  - Expected: `if_rvalid`=0, state=BOOT, `starve_cnt`=0.
